// File: rtl/i2s_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_slave_rx
//  Description : Slave-mode I2S serial receiver. Oversamples externally
//                driven sck/ws/sd in the clk_i domain and deserialises
//                I2S, MSB-justified and LSB-justified frames (8/16/24/32 b)
//                into right-aligned PCM words behind a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_slave_rx #(
    parameter int DATA_WIDTH = 32   // must not exceed 32 (shift register width)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [1:0]            fmt_i,
    input  logic [1:0]            dtl_i,
    input  logic                  pol_i,
    input  logic                  sck_i,
    input  logic                  ws_i,
    input  logic                  sd_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  chl_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  ovf_o,
    output logic                  busy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SYNC   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    localparam logic [1:0] FMT_I2S  = 2'b00;
    localparam logic [1:0] FMT_LSB  = 2'b10;
    localparam logic [1:0] FMT_NONE = 2'b11;

    // Synchroniser and edge-detect flops
    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic ws_s1_q, ws_s2_q;
    logic sd_s1_q, sd_s2_q;

    // Serial-side state
    logic [1:0]  state_q, state_d;
    logic [31:0] sr_q, sr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        chl_lat_q, chl_lat_d;
    logic        ws_d1_q, ws_d1_d;
    logic        ws_ref_d_q, ws_ref_d_d;

    // Output-side state
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  chl_q, chl_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;

    // Combinational helpers
    logic        w_se;
    logic        w_ws_ref;
    logic        w_tr;
    logic        w_run_edge;
    logic [5:0]  w_n;
    logic [31:0] w_mask;
    logic [31:0] w_shift;
    logic        w_done;
    logic [31:0] w_word;
    logic        w_word_chl;

    // Two-flop synchronisers on all serial pins, plus a third sck flop for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_s1_q <= 1'b0;
            sck_s2_q <= 1'b0;
            sck_s3_q <= 1'b0;
            ws_s1_q  <= 1'b0;
            ws_s2_q  <= 1'b0;
            sd_s1_q  <= 1'b0;
            sd_s2_q  <= 1'b0;
        end else begin
            sck_s1_q <= sck_i;
            sck_s2_q <= sck_s1_q;
            sck_s3_q <= sck_s2_q;
            ws_s1_q  <= ws_i;
            ws_s2_q  <= ws_s1_q;
            sd_s1_q  <= sd_i;
            sd_s2_q  <= sd_s1_q;
        end
    end

    // Sample strobe on the selected sck edge; ws/sd share the same sync delay
    assign w_se = pol_i ? (sck_s3_q & ~sck_s2_q) : (~sck_s3_q & sck_s2_q);

    // I2S frames lag ws by one bit, so the delayed ws marks the word boundary
    assign w_ws_ref   = (fmt_i == FMT_I2S) ? ws_d1_q : ws_s2_q;
    assign w_tr       = (w_ws_ref != ws_ref_d_q);
    assign w_run_edge = (state_q == S_RUN) ||
                        ((state_q == S_SYNC) && w_tr && (fmt_i != FMT_NONE));
    assign w_shift    = {sr_q[30:0], sd_s2_q};

    // Word length and the matching right-aligned mask
    always_comb begin
        w_n    = 6'd8;
        w_mask = 32'h0000_00FF;
        case (dtl_i)
            2'b00: begin w_n = 6'd8;  w_mask = 32'h0000_00FF; end
            2'b01: begin w_n = 6'd16; w_mask = 32'h0000_FFFF; end
            2'b10: begin w_n = 6'd24; w_mask = 32'h00FF_FFFF; end
            default: begin w_n = 6'd32; w_mask = 32'hFFFF_FFFF; end
        endcase
    end

    // Frame tracking, bit counting and word-completion detection
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        chl_lat_d  = chl_lat_q;
        ws_d1_d    = ws_d1_q;
        ws_ref_d_d = ws_ref_d_q;
        w_done     = 1'b0;
        w_word     = 32'd0;
        w_word_chl = 1'b0;
        if (!en_i || (state_q == S_IDLE)) begin
            state_d    = en_i ? S_SYNC : S_IDLE;
            sr_d       = 32'd0;
            cnt_d      = 6'd0;
            chl_lat_d  = 1'b0;
            ws_d1_d    = 1'b0;
            ws_ref_d_d = 1'b0;
        end else if (w_se) begin
            ws_d1_d    = ws_s2_q;
            ws_ref_d_d = w_ws_ref;
            if ((state_q == S_SYNC) && w_tr && (fmt_i != FMT_NONE)) begin
                state_d = S_RUN;
            end
            if (w_run_edge) begin
                if (fmt_i == FMT_LSB) begin
                    // Word ends at the ws edge; the very first edge has no
                    // full word behind it, so only RUN-state edges emit.
                    sr_d = w_shift;
                    if (w_tr && (state_q == S_RUN)) begin
                        w_done     = 1'b1;
                        w_word     = sr_q & w_mask;
                        w_word_chl = ws_ref_d_q;
                    end
                end else if (w_tr) begin
                    sr_d      = {31'd0, sd_s2_q};
                    cnt_d     = 6'd1;
                    chl_lat_d = w_ws_ref;
                end else if (cnt_q < w_n) begin
                    sr_d  = w_shift;
                    cnt_d = cnt_q + 6'd1;
                    if ((cnt_q + 6'd1) == w_n) begin
                        w_done     = 1'b1;
                        w_word     = w_shift & w_mask;
                        w_word_chl = chl_lat_q;
                    end
                end
            end
        end
    end

    // Output handshake: load on completion if the slot is free or being drained
    always_comb begin
        data_d  = data_q;
        chl_d   = chl_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (!en_i || (state_q == S_IDLE)) begin
            data_d  = '0;
            chl_d   = 1'b0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
            if (w_done) begin
                if (!valid_q || ready_i) begin
                    data_d  = w_word[DATA_WIDTH-1:0];
                    chl_d   = w_word_chl;
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            sr_q       <= 32'd0;
            cnt_q      <= 6'd0;
            chl_lat_q  <= 1'b0;
            ws_d1_q    <= 1'b0;
            ws_ref_d_q <= 1'b0;
            data_q     <= '0;
            chl_q      <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            chl_lat_q  <= chl_lat_d;
            ws_d1_q    <= ws_d1_d;
            ws_ref_d_q <= ws_ref_d_d;
            data_q     <= data_d;
            chl_q      <= chl_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign data_o  = data_q;
    assign chl_o   = chl_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;
    assign busy_o  = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_i2s_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_slave_rx
//  Description : Directed self-checking bench for i2s_slave_rx. Drives
//                serial frames bit by bit and compares received words,
//                flags and handshake against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_slave_rx;

    localparam logic [1:0] F_I2S = 2'b00;
    localparam logic [1:0] F_MSB = 2'b01;
    localparam logic [1:0] F_LSB = 2'b10;
    localparam logic [1:0] F_NON = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_i, en_i, pol_i, sck_i, ws_i, sd_i, ready_i;
    logic [1:0]  fmt_i, dtl_i;
    logic [31:0] data_o;
    logic        chl_o, valid_o, ovf_o, busy_o;

    int          checks = 0;
    int          errors = 0;
    logic        prev_bit;
    logic [32:0] rxq[$];

    i2s_slave_rx #(.DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .fmt_i(fmt_i), .dtl_i(dtl_i),
        .pol_i(pol_i), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
        .data_o(data_o), .chl_o(chl_o), .valid_o(valid_o), .ready_i(ready_i),
        .ovf_o(ovf_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every accepted word as {chl, data}
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) rxq.push_back({chl_o, data_o});
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One sck period: launch edge, 4 clk, sample edge, 4 clk. Optionally
    // pulses ready_i exactly in the cycle the sample strobe is seen.
    task automatic send_bit(input logic ws, input logic sd, input bit pulse);
        sck_i = pol_i ? 1'b1 : 1'b0;
        ws_i  = ws;
        sd_i  = sd;
        repeat (4) begin @(posedge clk_i); #1; end
        sck_i = ~sck_i;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            if (pulse && k == 1) ready_i = 1'b1;
            if (pulse && k == 2) ready_i = 1'b0;
        end
    endtask

    task automatic preamble(input int n, input logic ws);
        for (int i = 0; i < n; i++) send_bit(ws, 1'b0, 1'b0);
    endtask

    // Left slot (ws=0) then right slot (ws=1), S sck each, N-bit words.
    // Unused bit positions carry 1s as junk.
    task automatic send_frame(input logic [1:0] f, input int S, input int N,
                              input logic [31:0] L, input logic [31:0] R,
                              input int pulse_at, input int nbits);
        logic [31:0] w;
        int          slot, j, k;
        logic        b_msb, b_lsb, sd;
        for (int i = 0; i < nbits; i++) begin
            slot  = i / S;
            j     = i % S;
            k     = S - 1 - j;
            w     = (slot != 0) ? R : L;
            b_msb = (j < N) ? w[N-1-j] : 1'b1;
            b_lsb = (k < N) ? w[k] : 1'b1;
            if (f == F_I2S) begin
                sd       = prev_bit;
                prev_bit = b_msb;
            end else if (f == F_MSB) begin
                sd = b_msb;
            end else begin
                sd = b_lsb;
            end
            send_bit(slot != 0, sd, i == pulse_at);
        end
    endtask

    task automatic send_trailer(input bit pulse);
        send_bit(1'b0, prev_bit, pulse);
        prev_bit = 1'b0;
    endtask

    task automatic configure(input logic [1:0] f, input logic [1:0] d, input logic p);
        en_i = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
        fmt_i    = f;
        dtl_i    = d;
        pol_i    = p;
        prev_bit = 1'b0;
        rxq.delete();
        @(posedge clk_i); #1;
        en_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (3) begin @(posedge clk_i); #1; end
        checks++; if (data_o !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
        checks++; if (chl_o !== 1'b0)    begin errors++; $display("FAIL reset_chl: got %b want 0", chl_o); end
        checks++; if (valid_o !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (ovf_o !== 1'b0)    begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
        checks++; if (busy_o !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_i2s16;
        logic [32:0] exp[2];
        exp = '{{1'b0, 32'h0000A5C3}, {1'b1, 32'h00001234}};
        ready_i = 1'b1;
        configure(F_I2S, 2'b01, 1'b0);
        preamble(4, 1'b1);
        send_frame(F_I2S, 16, 16, 32'hA5C3, 32'h1234, -1, 32);
        send_trailer(1'b0);
        repeat (4) begin @(posedge clk_i); #1; end
        checks++; if (rxq.size() != 2) begin errors++; $display("FAIL i2s16_count: got %0d want 2", rxq.size()); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rxq.size() <= k || rxq[k] !== exp[k]) begin
                errors++; $display("FAIL i2s16_word%0d: got %h want %h", k, (rxq.size() > k) ? rxq[k] : 33'h0, exp[k]);
            end
        end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL i2s16_ovf: got %b want 0", ovf_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL i2s16_busy: got %b want 1", busy_o); end
    endtask

    task automatic test_msb24;
        logic [32:0] exp[2];
        exp = '{{1'b0, 32'h00ABCDEF}, {1'b1, 32'h00123456}};
        ready_i = 1'b1;
        configure(F_MSB, 2'b10, 1'b0);
        preamble(4, 1'b1);
        send_frame(F_MSB, 32, 24, 32'hABCDEF, 32'h123456, -1, 64);
        repeat (4) begin @(posedge clk_i); #1; end
        checks++; if (rxq.size() != 2) begin errors++; $display("FAIL msb24_count: got %0d want 2", rxq.size()); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rxq.size() <= k || rxq[k] !== exp[k]) begin
                errors++; $display("FAIL msb24_word%0d: got %h want %h", k, (rxq.size() > k) ? rxq[k] : 33'h0, exp[k]);
            end
        end
    endtask

    task automatic test_lsb8;
        logic [32:0] exp[3];
        exp = '{{1'b1, 32'h3C}, {1'b0, 32'h5A}, {1'b1, 32'h81}};
        ready_i = 1'b1;
        configure(F_LSB, 2'b00, 1'b0);
        preamble(4, 1'b0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL lsb8_sync_busy: got %b want 0", busy_o); end
        send_frame(F_LSB, 32, 8, 32'h00, 32'h3C, -1, 64);
        checks++; if (rxq.size() != 0) begin errors++; $display("FAIL lsb8_first_tr: got %0d words want 0", rxq.size()); end
        send_frame(F_LSB, 32, 8, 32'h5A, 32'h81, -1, 64);
        send_trailer(1'b0);
        repeat (4) begin @(posedge clk_i); #1; end
        checks++; if (rxq.size() != 3) begin errors++; $display("FAIL lsb8_count: got %0d want 3", rxq.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rxq.size() <= k || rxq[k] !== exp[k]) begin
                errors++; $display("FAIL lsb8_word%0d: got %h want %h", k, (rxq.size() > k) ? rxq[k] : 33'h0, exp[k]);
            end
        end
    endtask

    task automatic test_pol1_32;
        logic [32:0] exp[2];
        exp = '{{1'b0, 32'hDEADBEEF}, {1'b1, 32'h0F0F1234}};
        ready_i = 1'b1;
        configure(F_I2S, 2'b11, 1'b1);
        preamble(4, 1'b1);
        send_frame(F_I2S, 32, 32, 32'hDEADBEEF, 32'h0F0F1234, -1, 64);
        send_trailer(1'b0);
        repeat (4) begin @(posedge clk_i); #1; end
        checks++; if (rxq.size() != 2) begin errors++; $display("FAIL pol1_count: got %0d want 2", rxq.size()); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rxq.size() <= k || rxq[k] !== exp[k]) begin
                errors++; $display("FAIL pol1_word%0d: got %h want %h", k, (rxq.size() > k) ? rxq[k] : 33'h0, exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        ready_i = 1'b0;
        configure(F_I2S, 2'b00, 1'b0);
        preamble(4, 1'b1);
        send_frame(F_I2S, 8, 8, 32'h11, 32'h22, -1, 16);
        checks++; if (valid_o !== 1'b1 || data_o !== 32'h11) begin errors++; $display("FAIL bp_first: got v=%b d=%h want v=1 d=11", valid_o, data_o); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL bp_no_ovf_yet: got %b want 0", ovf_o); end
        send_frame(F_I2S, 8, 8, 32'h33, 32'h44, -1, 16);
        checks++; if (data_o !== 32'h11 || chl_o !== 1'b0) begin errors++; $display("FAIL bp_held: got d=%h c=%b want d=11 c=0", data_o, chl_o); end
        checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b want 1", ovf_o); end
        send_trailer(1'b1);
        checks++; if (valid_o !== 1'b1 || data_o !== 32'h44 || chl_o !== 1'b1) begin
            errors++; $display("FAIL bp_same_cycle_load: got v=%b d=%h c=%b want v=1 d=44 c=1", valid_o, data_o, chl_o);
        end
        ready_i = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", valid_o); end
    endtask

    task automatic test_rst_enable;
        // Asynchronous reset in the middle of a frame
        ready_i = 1'b0;
        configure(F_I2S, 2'b01, 1'b0);
        preamble(4, 1'b1);
        send_frame(F_I2S, 16, 16, 32'hA5C3, 32'h1234, -1, 24);
        checks++; if (valid_o !== 1'b1 || data_o !== 32'hA5C3) begin errors++; $display("FAIL rst_pre: got v=%b d=%h want v=1 d=a5c3", valid_o, data_o); end
        #2 rst_i = 1'b1;
        #2;
        checks++; if (data_o !== 32'd0 || valid_o !== 1'b0 || chl_o !== 1'b0 || ovf_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got d=%h v=%b c=%b o=%b b=%b want all 0", data_o, valid_o, chl_o, ovf_o, busy_o);
        end
        @(posedge clk_i); #1;
        rst_i    = 1'b0;
        prev_bit = 1'b0;
        for (int i = 0; i < 20; i++) send_bit(1'b0, i[0], 1'b0);
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL rst_no_tr: got b=%b v=%b want 0 0", busy_o, valid_o); end

        // en_i drop mid-word with a pending word and a sticky overflow
        preamble(4, 1'b1);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL en_run: got %b want 1", busy_o); end
        send_frame(F_I2S, 16, 16, 32'h1111, 32'h2222, -1, 32);
        send_frame(F_I2S, 16, 16, 32'h3333, 32'h4444, -1, 8);
        checks++; if (valid_o !== 1'b1 || ovf_o !== 1'b1 || data_o !== 32'h1111) begin
            errors++; $display("FAIL en_pre: got v=%b o=%b d=%h want v=1 o=1 d=1111", valid_o, ovf_o, data_o);
        end
        en_i = 1'b0;
        @(posedge clk_i); #1;
        checks++; if (data_o !== 32'd0 || valid_o !== 1'b0 || chl_o !== 1'b0 || ovf_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL en_drop: got d=%h v=%b c=%b o=%b b=%b want all 0", data_o, valid_o, chl_o, ovf_o, busy_o);
        end
        en_i     = 1'b1;
        prev_bit = 1'b0;
        for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b1, 1'b0);
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL en_no_tr: got b=%b v=%b want 0 0", busy_o, valid_o); end
        preamble(4, 1'b1);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL en_resync: got %b want 1", busy_o); end
    endtask

    task automatic test_fmt_none;
        ready_i = 1'b1;
        configure(F_NON, 2'b00, 1'b0);
        preamble(4, 1'b1);
        send_frame(F_NON, 8, 8, 32'hC3, 32'h3C, -1, 16);
        send_trailer(1'b0);
        checks++; if (busy_o !== 1'b0 || rxq.size() != 0) begin
            errors++; $display("FAIL fmt_none: got b=%b words=%0d want 0 0", busy_o, rxq.size());
        end
    endtask

    initial begin
        rst_i    = 1'b1;
        en_i     = 1'b0;
        fmt_i    = F_I2S;
        dtl_i    = 2'b01;
        pol_i    = 1'b0;
        sck_i    = 1'b0;
        ws_i     = 1'b0;
        sd_i     = 1'b0;
        ready_i  = 1'b1;
        prev_bit = 1'b0;
        @(posedge clk_i); #1;
        test_reset();
        test_i2s16();
        test_msb24();
        test_lsb8();
        test_pol1_32();
        test_back_to_back();
        test_rst_enable();
        test_fmt_none();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
